ppu_vram_port: RTL and testbench
================================

// Module: ppu_vram_port
// PURPOSE
//  Responder side of the PPU renderer's fetch interface. Owns the scroll/address
//  registers v, t, fine_x and the write toggle w, plus the CPU $2000/$2002/$2005/$2006/$2007 decode.
//  Turns renderer fetch strobes and CPU PPUDATA accesses into one VRAM port,
//  returns pattern/nametable bytes and the decoded 2-bit attribute, and applies v_inc*/v_reset* updates.
// PARAMETERS
//  none
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous reset, active-high
//  reg_addr       in   3   CPU PPU register select (0..7 = $2000..$2007)
//  reg_wr/reg_rd  in   1   single-cycle CPU register write/read strobes
//  reg_din        in   8   CPU write data
//  reg_dout       out  8   PPUDATA read buffer (valid when reg_addr==7)
//  ppuctrl        in   8   bit2: PPUDATA increment (0:+1, 1:+32)
//  render_active  in   1   renderer fetching (rendering enabled and not vblank)
//  fetch_tile, fetch_attr, fetch_chr  in 1  renderer fetch strobes
//  pattern_idx    in   13  CHR address for fetch_chr
//  v_incx, v_incy, v_resetx, v_resety  in 1  renderer v-update strobes
//  fine_x         out  3   fine X scroll to renderer
//  fine_y         out  3   v[14:12] to renderer
//  data_o         out  8   byte to renderer (= vram_din)
//  attr_o         out  2   attribute quadrant bits to renderer
//  vram_addr      out  14  VRAM address
//  vram_rd/vram_wr out 1   VRAM strobes; vram_din in 8 (valid 1 cycle after vram_rd); vram_dout out 8
// BEHAVIOUR
//  - Reset: v=t=0, fine_x=0, w=0, read buffer=0, vram_rd=vram_wr=0, state IDLE, pending cleared.
//  - $2000 wr: t[11:10]=d[1:0]. $2002 rd: w=0.
//  - $2005 wr w=0: t[4:0]=d[7:3], fine_x=d[2:0], w=1; w=1: t[14:12]=d[2:0], t[9:5]=d[7:3], w=0.
//  - $2006 wr w=0: t[13:8]=d[5:0], t[14]=0, w=1; w=1: t[7:0]=d, v<=new t (same edge), w=0.
//  - Render fetch (render_active=1): vram_rd=1 while any fetch strobe is high; address:
//    fetch_tile 0x2000|v[11:0]; fetch_attr 0x23C0|v[11:10]<<10|v[9:7]<<3|v[4:2]; fetch_chr {0,pattern_idx}.
//    At fetch_attr latch q={v[6],v[1]}; attr_o = vram_din[2q+1:2q] (combinational on vram_din).
//  - v_incx: v[4:0]==31 -> v[4:0]=0, v[10]^=1; else +1.
//  - v_incy: fine_y<7 -> +1; else fine_y=0 and coarse_y (v[9:5]): 29 -> 0 with v[11]^=1; 31 -> 0 without toggle; else +1.
//  - v_resetx: v[10],v[4:0] <= t. v_resety: v[14:11],v[9:5] <= t.
//  - Update rules:
//    - incx and incy in one cycle both apply (disjoint fields).
//    - A CPU $2006 second write in the same cycle overrides all render updates.
//  - PPUDATA FSM: IDLE -> ACCESS -> (read only) CAPTURE -> IDLE.
//    - $2007 wr/rd with render_active=0 sets pending. In ACCESS: vram_addr=v[13:0], one-cycle strobe,
//      vram_dout=write data, v += ppuctrl[2]?32:1 (15-bit wrap).
//    - CAPTURE: buffer<=vram_din.
//    - A read returns the old buffer on reg_dout the same cycle.
//    - A new $2007 access while not IDLE is dropped.
//  - $2007 access with render_active=1: no VRAM strobe; v gets incx+incy as above (hardware glitch).
//  - VRAM port priority: render fetch over CPU. An ACCESS cycle never coincides with render_active=1.
//    If render_active rises while pending, pending stalls in IDLE until it falls.
//  - Reset mid-access aborts with no strobe on the next cycle.
// TESTING
//  - $2005 wr 0x7D then 0x5E -> fine_x=5, t=0x616F, w=0.
//  - $2006 wr 0x21,0x08 -> v=0x2108; $2007 wr 0xAB (ppuctrl=0) -> vram_wr addr 0x2108 dout 0xAB, v=0x2109;
//    ppuctrl[2]=1 -> v=0x2129.
//  - v=0x2000, mem[0x2000]=0x55, buffer=0: first $2007 rd returns 0x00, second returns 0x55.
//  - v=0x001F + v_incx -> v=0x0400. v=0x73A0 + v_incy -> v=0x0800. Both strobes on v=0x73BF -> v=0x0C00.
//  - v=0x0042, fetch_attr -> vram_addr=0x23C0; vram_din=0xC0 -> attr_o=3.
//  - $2007 wr with render_active=1 -> no vram_wr, v incx+incy applied.
//  - rst during pending read -> no strobe, buffer=0.

Source files
------------

// File: rtl/ppu_vram_port.sv
// ppu_vram_port
//   Responder side of the PPU renderer fetch interface. Holds the loopy
//   scroll registers (v, t, fine_x, w), decodes CPU writes/reads of
//   $2000/$2002/$2005/$2006/$2007 and merges renderer fetches and CPU PPUDATA
//   accesses onto a single VRAM port.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   reg_addr/reg_wr/reg_rd/
//   reg_din/reg_dout             CPU register interface (reg_dout = PPUDATA buffer)
//   ppuctrl                      bit2 selects the PPUDATA increment (+1 / +32)
//   render_active                renderer owns the VRAM port
//   fetch_tile/attr/chr,
//   pattern_idx                  renderer fetch strobes and CHR address
//   v_incx/v_incy/v_resetx/
//   v_resety                     renderer scroll updates
//   fine_x, fine_y               scroll to renderer
//   data_o, attr_o               fetched byte / decoded attribute bits
//   vram_addr/rd/wr/din/dout     VRAM port (din valid one cycle after rd)
module ppu_vram_port (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  reg_addr,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  input  logic [7:0]  ppuctrl,
  input  logic        render_active,
  input  logic        fetch_tile,
  input  logic        fetch_attr,
  input  logic        fetch_chr,
  input  logic [12:0] pattern_idx,
  input  logic        v_incx,
  input  logic        v_incy,
  input  logic        v_resetx,
  input  logic        v_resety,
  output logic [2:0]  fine_x,
  output logic [2:0]  fine_y,
  output logic [7:0]  data_o,
  output logic [1:0]  attr_o,
  output logic [13:0] vram_addr,
  output logic        vram_rd,
  output logic        vram_wr,
  input  logic [7:0]  vram_din,
  output logic [7:0]  vram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

  state_t      state;
  logic [14:0] v, t, v_r, v_step;
  logic        w;
  logic [7:0]  rbuf;
  logic        pending, pend_wr;
  logic [7:0]  pend_data;
  logic [1:0]  attr_q;

  logic wr0, wr5, wr6, rd2, cpu_data, glitch, incx, incy, fetch_any;

  // only bit 2 of PPUCTRL matters here
  logic unused_ctrl;
  assign unused_ctrl = ^{ppuctrl[7:3], ppuctrl[1:0]};

  assign wr0      = reg_wr && reg_addr == 3'd0;
  assign wr5      = reg_wr && reg_addr == 3'd5;
  assign wr6      = reg_wr && reg_addr == 3'd6;
  assign rd2      = reg_rd && reg_addr == 3'd2;
  assign cpu_data = (reg_wr || reg_rd) && reg_addr == 3'd7;
  // PPUDATA touched mid-render bumps v like a coarse-x plus y increment
  assign glitch   = cpu_data && render_active;
  assign incx     = v_incx || glitch;
  assign incy     = v_incy || glitch;
  assign v_step   = ppuctrl[2] ? 15'd32 : 15'd1;

  assign fine_y    = v[14:12];
  assign data_o    = vram_din;
  assign reg_dout  = rbuf;
  assign vram_dout = pend_data;
  assign fetch_any = render_active && (fetch_tile || fetch_attr || fetch_chr);

  // Renderer v update; x fields (v[10], v[4:0]) and y fields
  // (v[14:11], v[9:5]) are disjoint so incx and incy combine freely.
  always_comb begin
    v_r = v;
    if (incx) begin
      if (v[4:0] == 5'd31) begin
        v_r[4:0] = 5'd0;
        v_r[10]  = ~v[10];
      end else begin
        v_r[4:0] = v[4:0] + 5'd1;
      end
    end
    if (incy) begin
      if (v[14:12] != 3'd7) begin
        v_r[14:12] = v[14:12] + 3'd1;
      end else begin
        v_r[14:12] = 3'd0;
        if (v[9:5] == 5'd29) begin
          v_r[9:5] = 5'd0;
          v_r[11]  = ~v[11];
        end else if (v[9:5] == 5'd31) begin
          v_r[9:5] = 5'd0;
        end else begin
          v_r[9:5] = v[9:5] + 5'd1;
        end
      end
    end
    if (v_resetx) begin
      v_r[10]  = t[10];
      v_r[4:0] = t[4:0];
    end
    if (v_resety) begin
      v_r[14:11] = t[14:11];
      v_r[9:5]   = t[9:5];
    end
  end

  // VRAM port: renderer fetch wins over the CPU access cycle
  always_comb begin
    vram_addr = v[13:0];
    vram_rd   = 1'b0;
    vram_wr   = 1'b0;
    if (fetch_any) begin
      vram_rd = 1'b1;
      if (fetch_tile)
        vram_addr = {2'b10, v[11:0]};
      else if (fetch_attr)
        vram_addr = {2'b10, v[11:10], 4'b1111, v[9:7], v[4:2]};
      else
        vram_addr = {1'b0, pattern_idx};
    end else if (state == ACCESS) begin
      vram_rd = ~pend_wr;
      vram_wr = pend_wr;
    end
  end

  always_comb begin
    case (attr_q)
      2'd0:    attr_o = vram_din[1:0];
      2'd1:    attr_o = vram_din[3:2];
      2'd2:    attr_o = vram_din[5:4];
      default: attr_o = vram_din[7:6];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      attr_q <= 2'd0;
    else if (render_active && fetch_attr)
      attr_q <= {v[6], v[1]};
  end

  // Scroll registers; a $2006 second write is last so it overrides
  // every other v update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      v      <= 15'd0;
      t      <= 15'd0;
      fine_x <= 3'd0;
      w      <= 1'b0;
    end else begin
      if (state == ACCESS) v <= v + v_step;
      else                 v <= v_r;
      if (wr0) t[11:10] <= reg_din[1:0];
      if (rd2) w <= 1'b0;
      if (wr5) begin
        if (!w) begin
          t[4:0] <= reg_din[7:3];
          fine_x <= reg_din[2:0];
        end else begin
          t[14:12] <= reg_din[2:0];
          t[9:5]   <= reg_din[7:3];
        end
        w <= ~w;
      end
      if (wr6) begin
        if (!w) begin
          t[13:8] <= reg_din[5:0];
          t[14]   <= 1'b0;
        end else begin
          t[7:0] <= reg_din;
          v      <= {t[14:8], reg_din};
        end
        w <= ~w;
      end
    end
  end

  // PPUDATA access FSM; pending waits in IDLE while the renderer is active
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      pend_wr   <= 1'b0;
      pend_data <= 8'd0;
      rbuf      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pending && !render_active) begin
            state   <= ACCESS;
            pending <= 1'b0;
          end else if (cpu_data && !render_active && !pending) begin
            pending   <= 1'b1;
            pend_wr   <= reg_wr;
            pend_data <= reg_din;
          end
        end
        ACCESS:  state <= pend_wr ? IDLE : CAPTURE;
        CAPTURE: begin
          rbuf  <= vram_din;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_vram_port.sv
module tb_ppu_vram_port;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  reg_addr = '0;
  logic        reg_wr = 1'b0, reg_rd = 1'b0;
  logic [7:0]  reg_din = '0, reg_dout;
  logic [7:0]  ppuctrl = '0;
  logic        render_active = 1'b0;
  logic        fetch_tile = 1'b0, fetch_attr = 1'b0, fetch_chr = 1'b0;
  logic [12:0] pattern_idx = '0;
  logic        v_incx = 1'b0, v_incy = 1'b0, v_resetx = 1'b0, v_resety = 1'b0;
  logic [2:0]  fine_x, fine_y;
  logic [7:0]  data_o;
  logic [1:0]  attr_o;
  logic [13:0] vram_addr;
  logic        vram_rd, vram_wr;
  logic [7:0]  vram_din = '0, vram_dout;

  ppu_vram_port dut (
    .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_din(reg_din), .reg_dout(reg_dout), .ppuctrl(ppuctrl),
    .render_active(render_active), .fetch_tile(fetch_tile), .fetch_attr(fetch_attr),
    .fetch_chr(fetch_chr), .pattern_idx(pattern_idx), .v_incx(v_incx), .v_incy(v_incy),
    .v_resetx(v_resetx), .v_resety(v_resety), .fine_x(fine_x), .fine_y(fine_y),
    .data_o(data_o), .attr_o(attr_o), .vram_addr(vram_addr), .vram_rd(vram_rd),
    .vram_wr(vram_wr), .vram_din(vram_din), .vram_dout(vram_dout)
  );

  always #5 clk = ~clk;

  // VRAM model: read data appears one cycle after vram_rd
  logic [7:0] mem [0:16383];
  always @(posedge clk) begin
    if (vram_rd) vram_din <= mem[vram_addr];
    if (vram_wr) mem[vram_addr] <= vram_dout;
  end

  typedef struct packed {
    logic        wr;
    logic [13:0] addr;
    logic [7:0]  dout;
    logic [2:0]  fy;
    logic [2:0]  fx;
  } port_t;

  port_t      pq[$];
  string      pn[$];
  logic [7:0] dq[$];
  string      dn[$];
  int compared = 0, mismatched = 0;
  logic [1:0] due = 2'd0;

  task automatic chk_data(input logic [7:0] act);
    logic [7:0] e;
    string n;
    compared++;
    if (dq.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected data output: got %02h, none expected", act);
    end else begin
      e = dq.pop_front();
      n = dn.pop_front();
      if (act !== e) begin
        mismatched++;
        $display("FAIL %s: got %02h, expected %02h", n, act, e);
      end
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    port_t a, e;
    string n;
    if (due == 2'd1) chk_data({6'd0, attr_o});
    if (due == 2'd2) chk_data(data_o);
    if (reg_rd && reg_addr == 3'd7) chk_data(reg_dout);
    if (vram_rd || vram_wr) begin
      a = '{wr: vram_wr, addr: vram_addr, dout: (vram_wr ? vram_dout : 8'd0),
            fy: fine_y, fx: fine_x};
      compared++;
      if (pq.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected vram strobe: got rd=%b wr=%b addr=%04h", vram_rd, vram_wr, vram_addr);
      end else begin
        e = pq.pop_front();
        n = pn.pop_front();
        if (a !== e || vram_rd === vram_wr) begin
          mismatched++;
          $display("FAIL %s: got wr=%b addr=%04h dout=%02h fy=%0d fx=%0d, expected wr=%b addr=%04h dout=%02h fy=%0d fx=%0d",
                   n, a.wr, a.addr, a.dout, a.fy, a.fx, e.wr, e.addr, e.dout, e.fy, e.fx);
        end
      end
    end
    due <= (render_active && fetch_attr) ? 2'd1 : (render_active && fetch_chr) ? 2'd2 : 2'd0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
    reg_addr = a; reg_din = d; reg_wr = 1'b1;
    tick(1);
    reg_wr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [2:0] a);
    reg_addr = a; reg_rd = 1'b1;
    tick(1);
    reg_rd = 1'b0;
  endtask

  task automatic exp_port(input string n, input logic wr, input logic [13:0] addr,
                          input logic [7:0] d, input logic [2:0] fy, input logic [2:0] fx);
    pq.push_back('{wr: wr, addr: addr, dout: d, fy: fy, fx: fx});
    pn.push_back(n);
  endtask

  task automatic exp_data(input string n, input logic [7:0] d);
    dq.push_back(d);
    dn.push_back(n);
  endtask

  // Observe v through a tile fetch: address carries v[11:0], fine_y carries v[14:12]
  task automatic probe(input string n, input logic [14:0] ev, input logic [2:0] fx);
    exp_port(n, 1'b0, {2'b10, ev[11:0]}, 8'd0, ev[14:12], fx);
    render_active = 1'b1; fetch_tile = 1'b1;
    tick(1);
    fetch_tile = 1'b0; render_active = 1'b0;
  endtask

  task automatic v_upd(input logic x, input logic y, input logic rx, input logic ry);
    render_active = 1'b1;
    v_incx = x; v_incy = y; v_resetx = rx; v_resety = ry;
    tick(1);
    v_incx = 1'b0; v_incy = 1'b0; v_resetx = 1'b0; v_resety = 1'b0;
    render_active = 1'b0;
  endtask

  task automatic fetch(input logic at, input logic [12:0] pidx);
    render_active = 1'b1; fetch_attr = at; fetch_chr = ~at; pattern_idx = pidx;
    tick(1);
    fetch_attr = 1'b0; fetch_chr = 1'b0; render_active = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h2000] = 8'h55;
    mem[14'h2001] = 8'h66;
    mem[14'h23C0] = 8'hE4;
    mem[14'h2FCF] = 8'h02;
    mem[14'h1ABC] = 8'h3C;
    tick(3);
    rst = 1'b0;

    probe("reset_v", 15'h0000, 3'd0);

    // $2005 pair, then copy t into v
    cpu_rd(3'd2);
    cpu_wr(3'd5, 8'h7D);
    cpu_wr(3'd5, 8'h5E);
    v_upd(1'b0, 1'b0, 1'b1, 1'b1);
    probe("scroll_t", 15'h616F, 3'd5);

    // $2006 pair and PPUDATA writes with both increments
    cpu_wr(3'd6, 8'h21);
    cpu_wr(3'd6, 8'h08);
    probe("addr_v", 15'h2108, 3'd5);
    exp_port("wr_inc1", 1'b1, 14'h2108, 8'hAB, 3'd2, 3'd5);
    cpu_wr(3'd7, 8'hAB);
    tick(3);
    probe("v_after_inc1", 15'h2109, 3'd5);
    ppuctrl = 8'h04;
    exp_port("wr_inc32", 1'b1, 14'h2109, 8'h11, 3'd2, 3'd5);
    cpu_wr(3'd7, 8'h11);
    tick(3);
    probe("v_after_inc32", 15'h2129, 3'd5);
    ppuctrl = 8'h00;

    // pending write stalls while render_active is high
    exp_port("wr_stalled", 1'b1, 14'h2129, 8'h22, 3'd2, 3'd5);
    cpu_wr(3'd7, 8'h22);
    render_active = 1'b1;
    tick(4);
    render_active = 1'b0;
    tick(3);
    probe("v_after_stall", 15'h212A, 3'd5);

    // buffered PPUDATA reads from a fresh reset
    rst = 1'b1; tick(2); rst = 1'b0;
    probe("reset_v2", 15'h0000, 3'd0);
    cpu_wr(3'd6, 8'h20);
    cpu_wr(3'd6, 8'h00);
    exp_data("rd1_buf", 8'h00);
    exp_port("rd1_port", 1'b0, 14'h2000, 8'd0, 3'd2, 3'd0);
    cpu_rd(3'd7);
    tick(4);
    exp_data("rd2_buf", 8'h55);
    exp_port("rd2_port", 1'b0, 14'h2001, 8'd0, 3'd2, 3'd0);
    cpu_rd(3'd7);
    tick(4);

    // coarse x wrap
    cpu_wr(3'd6, 8'h00);
    cpu_wr(3'd6, 8'h1F);
    v_upd(1'b1, 1'b0, 1'b0, 1'b0);
    probe("incx_wrap", 15'h0400, 3'd0);

    // fine_y/coarse_y wrap at row 29
    cpu_wr(3'd0, 8'h00);
    cpu_wr(3'd5, 8'h00);
    cpu_wr(3'd5, 8'hEF);
    v_upd(1'b0, 1'b0, 1'b1, 1'b1);
    probe("v_73A0", 15'h73A0, 3'd0);
    v_upd(1'b0, 1'b1, 1'b0, 1'b0);
    probe("incy_wrap", 15'h0800, 3'd0);

    // both increments together
    cpu_wr(3'd5, 8'hF8);
    cpu_wr(3'd5, 8'hEF);
    v_upd(1'b0, 1'b0, 1'b1, 1'b1);
    v_upd(1'b1, 1'b1, 1'b0, 1'b0);
    probe("incxy_both", 15'h0C00, 3'd0);

    // attribute fetches, one per quadrant plus a far nametable address
    cpu_wr(3'd6, 8'h00); cpu_wr(3'd6, 8'h42);
    exp_port("attr_addr_q3", 1'b0, 14'h23C0, 8'd0, 3'd0, 3'd0);
    exp_data("attr_q3", 8'd3);
    fetch(1'b1, 13'd0);
    cpu_wr(3'd6, 8'h00); cpu_wr(3'd6, 8'h02);
    exp_port("attr_addr_q1", 1'b0, 14'h23C0, 8'd0, 3'd0, 3'd0);
    exp_data("attr_q1", 8'd1);
    fetch(1'b1, 13'd0);
    cpu_wr(3'd6, 8'h00); cpu_wr(3'd6, 8'h40);
    exp_port("attr_addr_q2", 1'b0, 14'h23C0, 8'd0, 3'd0, 3'd0);
    exp_data("attr_q2", 8'd2);
    fetch(1'b1, 13'd0);
    cpu_wr(3'd6, 8'h0C); cpu_wr(3'd6, 8'h9C);
    exp_port("attr_addr_far", 1'b0, 14'h2FCF, 8'd0, 3'd0, 3'd0);
    exp_data("attr_far", 8'd2);
    fetch(1'b1, 13'd0);
    tick(1);

    // pattern fetch
    exp_port("chr_addr", 1'b0, 14'h1ABC, 8'd0, 3'd0, 3'd0);
    exp_data("chr_data", 8'h3C);
    fetch(1'b0, 13'h1ABC);
    tick(1);

    // PPUDATA write during rendering: no strobe, v gets incx+incy
    cpu_wr(3'd6, 8'h00); cpu_wr(3'd6, 8'h1F);
    render_active = 1'b1;
    cpu_wr(3'd7, 8'h99);
    render_active = 1'b0;
    tick(3);
    probe("glitch_v", 15'h1400, 3'd0);

    // reset while a read is pending: no strobe, buffer cleared
    cpu_wr(3'd6, 8'h20); cpu_wr(3'd6, 8'h00);
    exp_data("rd_before_rst", 8'h66);
    cpu_rd(3'd7);
    rst = 1'b1; tick(2); rst = 1'b0;
    tick(3);
    exp_data("rd_after_rst", 8'h00);
    exp_port("rd_after_rst_port", 1'b0, 14'h0000, 8'd0, 3'd0, 3'd0);
    cpu_rd(3'd7);
    tick(5);

    while (pq.size() > 0) begin
      compared++; mismatched++;
      $display("FAIL %s: expected vram access never seen", pn.pop_front());
      void'(pq.pop_front());
    end
    while (dq.size() > 0) begin
      compared++; mismatched++;
      $display("FAIL %s: expected data output never seen", dn.pop_front());
      void'(dq.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
